// File: rtl/fpga_pkg.sv
// Shared constants for the fpga configuration fabric: Wishbone region decode,
// register offsets and default geometry.
package fpga_pkg;

    localparam logic [7:0]  RegionBase     = 8'h30;
    localparam logic [7:0]  OffId          = 8'h00;
    localparam logic [7:0]  OffCnt         = 8'h04;
    localparam logic [7:0]  OffShift       = 8'h08;
    localparam int unsigned LanesPerRegion = 4;
    localparam logic [7:0]  CntReset       = 8'h08;

    localparam int unsigned MxDefault         = 6;
    localparam int unsigned MyDefault         = 7;
    localparam int unsigned TileBitsDefault   = 16;
    localparam int unsigned NumRegionsDefault = 2;

    function automatic logic region_hit(input logic [31:0] addr, input int unsigned region);
        return addr[31:24] == RegionBase + 8'(region);
    endfunction

endpackage

// File: rtl/fpga_cfg_region.sv
// One Wishbone config region: address decode, ack pulse, per-lane shift counts
// and the four column configuration chains it owns.
module fpga_cfg_region
    import fpga_pkg::*;
#(
    parameter int unsigned Region  = 0,
    parameter int unsigned Mx      = MxDefault,
    parameter int unsigned ColBits = TileBitsDefault * MyDefault
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              stb_i,
    input  logic                              cyc_i,
    input  logic                              we_i,
    input  logic [3:0]                        sel_i,
    input  logic [31:0]                       data_i,
    input  logic [31:0]                       addr_i,
    output logic                              ack_o,
    output logic [31:0]                       rdata_o,
    output logic [LanesPerRegion*ColBits-1:0] chain_o
);

    logic               ack_q;
    logic               req;
    logic [7:0]         off;
    logic [31:0]        rdata_d, rdata_q;
    logic [7:0]         cnt_d   [LanesPerRegion];
    logic [7:0]         cnt_q   [LanesPerRegion];
    logic [ColBits-1:0] chain_d [LanesPerRegion];
    logic [ColBits-1:0] chain_q [LanesPerRegion];

    // Shifts up to eight bits in one cycle, bit 0 first, entering at the MSB.
    function automatic logic [ColBits-1:0] shift_in(input logic [ColBits-1:0] chain,
                                                    input logic [7:0] bits,
                                                    input logic [7:0] n);
        logic [ColBits-1:0] c;
        c = chain;
        for (int b = 0; b < 8; b++) begin
            if (8'(b) < n) c = {bits[b], c[ColBits-1:1]};
        end
        return c;
    endfunction

    assign off = addr_i[7:0];
    assign req = stb_i & cyc_i & region_hit(addr_i, Region) & ~ack_q;

    always_comb begin
        rdata_d = '0;
        for (int l = 0; l < LanesPerRegion; l++) begin
            cnt_d[l]   = cnt_q[l];
            chain_d[l] = chain_q[l];
        end
        if (req && we_i) begin
            for (int l = 0; l < LanesPerRegion; l++) begin
                // Lanes past the last fabric column have no chain behind them.
                if (sel_i[l] && (int'(Region * LanesPerRegion) + l < int'(Mx))) begin
                    if (off == OffCnt) begin
                        cnt_d[l] = data_i[8*l +: 8];
                    end else if (off == OffShift) begin
                        chain_d[l] = shift_in(chain_q[l], data_i[8*l +: 8], cnt_q[l]);
                    end
                end
            end
        end else if (req && (off == OffCnt)) begin
            rdata_d = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int l = 0; l < LanesPerRegion; l++) begin
                cnt_q[l]   <= CntReset;
                chain_q[l] <= '0;
            end
        end else begin
            ack_q   <= req;
            rdata_q <= rdata_d;
            for (int l = 0; l < LanesPerRegion; l++) begin
                cnt_q[l]   <= cnt_d[l];
                chain_q[l] <= chain_d[l];
            end
        end
    end

    for (genvar l = 0; l < LanesPerRegion; l++) begin : g_lane
        assign chain_o[l*ColBits +: ColBits] = chain_q[l];
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/fpga.sv
// FPGA fabric top: config regions on Wishbone, tile config mapping from the
// column chains, and the fabric-reset-gated registered tile outputs.
module fpga
    import fpga_pkg::*;
#(
    parameter int MX                 = MxDefault,
    parameter int MY                 = MyDefault,
    parameter int TILE_BITS          = TileBitsDefault,
    parameter int NUM_CONFIG_REGIONS = NumRegionsDefault,
    parameter int S_XX_BASE          = 0,
    parameter int NUM_LUTS           = 1,
    parameter int WS                 = 4,
    parameter int WD                 = 8,
    parameter int CLBIN              = 10,
    parameter int CLBIN_EACH_SIDE    = 10,
    parameter int CLBOUT             = 5,
    parameter int CLBOUT_EACH_SIDE   = 5,
    parameter int CLBOS              = 2,
    parameter int CLBOD              = 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_data_i,
    input  logic [31:0]                   wbs_addr_i,
    output logic [NUM_CONFIG_REGIONS-1:0] wbs_ack_o,
    output logic [31:0]                   wbs_data_o,
    inout  wire  [9:0]                    gpio_north,
    inout  wire  [7:0]                    gpio_south,
    inout  wire  [9:0]                    gpio_east,
    inout  wire  [9:0]                    gpio_west,
    output logic [8*MX*MY-1:0]            tile_comb_o,
    output logic [8*MX*MY-1:0]            tile_sync_o
);

    localparam int COL_BITS = TILE_BITS * MY;
    localparam int RegBits  = LanesPerRegion * COL_BITS;

    logic [NUM_CONFIG_REGIONS*RegBits-1:0] chains;
    logic [31:0]                           rdata [NUM_CONFIG_REGIONS];
    logic                                  fabric_reset;
    logic [8*MX*MY-1:0]                    tile_sync_q;

    for (genvar r = 0; r < NUM_CONFIG_REGIONS; r++) begin : g_region
        fpga_cfg_region #(
            .Region  (r),
            .Mx      (MX),
            .ColBits (COL_BITS)
        ) u_region (
            .clk_i   (wb_clk_i),
            .rst_ni  (wb_rst_i),
            .stb_i   (wbs_stb_i),
            .cyc_i   (wbs_cyc_i),
            .we_i    (wbs_we_i),
            .sel_i   (wbs_sel_i),
            .data_i  (wbs_data_i),
            .addr_i  (wbs_addr_i),
            .ack_o   (wbs_ack_o[r]),
            .rdata_o (rdata[r]),
            .chain_o (chains[r*RegBits +: RegBits])
        );
    end

    // Idle regions hold zero read data, so OR-ing them is a safe mux.
    always_comb begin
        wbs_data_o = '0;
        for (int r = 0; r < NUM_CONFIG_REGIONS; r++) wbs_data_o = wbs_data_o | rdata[r];
    end

    // Tile row 0 sits at the top (MSB end) of its column chain.
    for (genvar x = 0; x < MX; x++) begin : g_col
        for (genvar y = 0; y < MY; y++) begin : g_row
            assign tile_comb_o[(x*MY+y)*8 +: 8] =
                chains[x*COL_BITS + COL_BITS - (y+1)*TILE_BITS +: 8];
        end
    end

    assign fabric_reset = gpio_north[9];
    assign gpio_south   = 'z;
    assign gpio_east    = 'z;
    assign gpio_west    = 'z;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tile_sync_q <= '0;
        end else if (fabric_reset) begin
            tile_sync_q <= '0;
        end else begin
            tile_sync_q <= tile_comb_o;
        end
    end

    assign tile_sync_o = tile_sync_q;

endmodule

// File: tb/tb_fpga.sv
// Scoreboard bench for fpga: transfers queue their expected ack/read data, a
// monitor checks each ack pulse; tile outputs are checked against a chain model.
module tb_fpga;

    localparam int NX   = 6;
    localparam int NY   = 7;
    localparam int COLB = 16 * NY;
    localparam int TW   = 8 * NX * NY;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   wdata = '0, addr = '0;
    logic [1:0]    ack;
    logic [31:0]   rdata;
    logic          fabric_reset = 1'b0;
    wire  [9:0]    gpio_north;
    wire  [7:0]    gpio_south;
    wire  [9:0]    gpio_east;
    wire  [9:0]    gpio_west;
    logic [TW-1:0] tile_comb, tile_sync;

    assign gpio_north[9] = fabric_reset;

    fpga u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_data_i  (wdata),
        .wbs_addr_i  (addr),
        .wbs_ack_o   (ack),
        .wbs_data_o  (rdata),
        .gpio_north  (gpio_north),
        .gpio_south  (gpio_south),
        .gpio_east   (gpio_east),
        .gpio_west   (gpio_west),
        .tile_comb_o (tile_comb),
        .tile_sync_o (tile_sync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  ack;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];

    logic [COLB-1:0] m_chain [NX];
    logic [7:0]      m_cnt   [8];

    task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NX; c++) m_chain[c] = '0;
        for (int l = 0; l < 8; l++) m_cnt[l] = 8'h08;
    endtask

    // Top n bits of the chain become d[n-1:0]; the rest moves down by n.
    task automatic model_shift(input int col, input logic [7:0] d);
        int n;
        logic [7:0] mask;
        logic [COLB-1:0] ext;
        n = (m_cnt[col] > 8) ? 8 : int'(m_cnt[col]);
        mask = 8'((9'd1 << n) - 9'd1);
        ext = COLB'(d & mask);
        m_chain[col] = (m_chain[col] >> n) | (ext << (COLB - n));
    endtask

    function automatic logic [TW-1:0] model_comb();
        logic [TW-1:0] v;
        logic [COLB-1:0] s;
        v = '0;
        for (int x = 0; x < NX; x++) begin
            for (int y = 0; y < NY; y++) begin
                s = m_chain[x] >> (COLB - 16 * (y + 1));
                v[(x*NY+y)*8 +: 8] = s[7:0];
            end
        end
        return v;
    endfunction

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [1:0] exp_ack,
                           input logic chk, input logic [31:0] exp_data, input string nm);
        int n;
        exp_q.push_back('{ack: exp_ack, chk: chk, data: exp_data});
        name_q.push_back(nm);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; wdata = d; addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 2'b00 && n < 8);
        if (ack == 2'b00) begin
            checks++;
            failures++;
            $display("FAIL %s: ack timeout, got ack=%b required %b", nm, ack, exp_ack);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr_cnt(input int r, input logic [3:0] s, input logic [31:0] d);
        for (int l = 0; l < 4; l++)
            if (s[l] && (4 * r + l < NX)) m_cnt[4*r+l] = d[8*l +: 8];
        wb_xfer(32'h3000_0004 + (32'(r) << 24), 1'b1, s, d, 2'(1 << r), 1'b0, '0, "cnt_wr");
    endtask

    task automatic wr_shift(input int r, input logic [3:0] s, input logic [31:0] d);
        for (int l = 0; l < 4; l++)
            if (s[l] && (4 * r + l < NX)) model_shift(4 * r + l, d[8*l +: 8]);
        wb_xfer(32'h3000_0008 + (32'(r) << 24), 1'b1, s, d, 2'(1 << r), 1'b0, '0, "shift_wr");
    endtask

    // Monitor: every ack must be a single-cycle pulse matching the queue head.
    initial begin : monitor
        logic [1:0] prev_ack;
        exp_t e;
        string nm;
        prev_ack = 2'b00;
        forever begin
            @(negedge clk);
            if (ack != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: got ack=%b required none", ack);
                end else begin
                    e = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (ack != e.ack || prev_ack != 2'b00 || (e.chk && rdata !== e.data)) begin
                        failures++;
                        $display("FAIL %s: got ack=%b prev=%b data=%h required ack=%b prev=00 data=%h",
                                 nm, ack, prev_ack, rdata, e.ack, e.data);
                    end
                end
            end
            prev_ack = ack;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [COLB-1:0] snap;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_comb", tile_comb, '0);
        check("reset_sync", tile_sync, '0);
        check("reset_ack", TW'(ack), '0);
        check("reset_rdata", TW'(rdata), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rdata", TW'(rdata), '0);

        wb_xfer(32'h3000_0004, 1'b0, 4'hF, '0, 2'b01, 1'b1, 32'h0808_0808, "rd_cnt_reset");
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, '0, 2'b01, 1'b1, 32'h0000_0000, "rd_off0");
        wb_xfer(32'h3000_0008, 1'b0, 4'hF, '0, 2'b01, 1'b1, 32'h0000_0000, "rd_off8");

        wr_cnt(0, 4'hF, 32'hFFFF_FFFF);
        wb_xfer(32'h3000_0004, 1'b0, 4'hF, '0, 2'b01, 1'b1, 32'hFFFF_FFFF, "rd_cnt_ff");

        for (int i = 0; i < 14; i++) wr_shift(0, 4'b0001, 32'h0000_00A5);
        @(negedge clk);
        for (int y = 0; y < NY; y++) check("a5_tile0", TW'(tile_comb[y*8 +: 8]), TW'(8'hA5));
        check("a5_model", tile_comb, model_comb());

        wr_cnt(0, 4'b0001, 32'h0000_0003);
        wr_shift(0, 4'b0001, 32'h0000_0005);
        @(negedge clk);
        check("cnt3_top_bits", TW'(u_dut.chains[COLB-1 -: 3]), TW'(3'b101));
        check("cnt3_model", tile_comb, model_comb());

        snap = m_chain[0];
        wr_cnt(0, 4'b0001, 32'h0000_0000);
        wr_shift(0, 4'b0001, 32'h0000_00FF);
        @(negedge clk);
        check("cnt0_unchanged", TW'(u_dut.chains[COLB-1:0]), TW'(snap));

        wr_shift(1, 4'b0011, 32'h1234_5678);
        @(negedge clk);
        check("r1_col4", TW'(u_dut.chains[4*COLB + COLB-1 -: 8]), TW'(8'h78));
        check("r1_col5", TW'(u_dut.chains[5*COLB + COLB-1 -: 8]), TW'(8'h56));
        check("r1_model", tile_comb, model_comb());

        wr_cnt(0, 4'hF, 32'hFFFF_FFFF);
        for (int i = 0; i < 14; i++) wr_shift(0, 4'hF, $urandom);
        for (int i = 0; i < 14; i++) wr_shift(1, 4'b0011, $urandom);
        @(negedge clk);
        check("bitstream_comb", tile_comb, model_comb());
        check("bitstream_sync", tile_sync, model_comb());

        fabric_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("fabric_reset_sync", tile_sync, '0);
        fabric_reset = 1'b0;
        @(negedge clk);
        check("fabric_release_sync", tile_sync, model_comb());

        wr_shift(0, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; wdata = 32'h5A5A_5A5A;
        addr = 32'h3000_0008;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_chains", TW'(u_dut.chains[NX*COLB-1:0]), '0);
        check("midreset_comb", tile_comb, '0);
        check("midreset_sync", tile_sync, '0);
        @(negedge clk);
        check("midreset_ack", TW'(ack), '0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        wb_xfer(32'h3000_0004, 1'b0, 4'hF, '0, 2'b01, 1'b1, 32'h0808_0808, "rd_cnt_after_rst");
        wr_shift(0, 4'b0001, 32'h0000_0081);
        @(negedge clk);
        check("post_reset_model", tile_comb, model_comb());

        repeat (3) @(negedge clk);
        check("queue_drained", TW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
